// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Shares one combinational ALU between two requesters. Each requester offers
// an ALU control code plus two operands over valid/ready; the block grants one
// of them round-robin, drives the shared ALU from registered operands for one
// EXEC cycle, then presents the registered result, zero flag and requester ID
// on a valid/ready response channel. At most one operation is in flight.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     requester N handshake (N = 0, 1)
//   reqN_ctrl, reqN_a, reqN_b   requester N ALU code and operands
//   alu_ctrl, alu_a, alu_b      registered operation driven to the shared ALU
//   alu_result, alu_zero        combinational answer from the shared ALU
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_result,
//   rsp_zero, rsp_err           registered response payload
//   busy                        high whenever the FSM is not idle
//
// Build option:
//   ALU_ARB_ILLEGAL_CHK_EN  when defined, codes outside AND/OR/ADD/SUB/SLT are
//                           answered directly with rsp_err=1 (no EXEC cycle,
//                           ALU registers untouched). When undefined, every
//                           code is forwarded and rsp_err is tied low.

module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             grant_id;
  logic             any_valid;
  logic             slot_free;
  logic             accept;
  logic [3:0]       sel_ctrl;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin choice: prio only matters when both requesters compete.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  // A new op can be taken when idle, or in RESP in the very cycle the current
  // response is consumed (back-to-back). Reset masks ready so no requester
  // believes it was accepted while the block is being cleared.
  assign any_valid  = req0_valid | req1_valid;
  assign slot_free  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept     = slot_free && any_valid && !reset;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  assign sel_ctrl = grant_id ? req1_ctrl : req0_ctrl;
  assign sel_a    = grant_id ? req1_a    : req0_a;
  assign sel_b    = grant_id ? req1_b    : req0_b;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic rsp_err_q, rsp_err_d;
  logic sel_illegal;

  always_comb begin
    sel_illegal = 1'b1;
    case (sel_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: sel_illegal = 1'b0;
      default: sel_illegal = 1'b1;
    endcase
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state logic. An accept always overrides the per-state transition
  // because it can only occur in IDLE or in a consumed RESP.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    rsp_err_d    = rsp_err_q;
`endif

    case (state_q)
      IDLE: state_d = IDLE;
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      prio_d   = ~grant_id;
      rsp_id_d = grant_id;
      state_d  = EXEC;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      if (sel_illegal) begin
        // Illegal codes never reach the ALU; answer immediately.
        state_d      = RESP;
        rsp_result_d = '0;
        rsp_zero_d   = 1'b0;
        rsp_err_d    = 1'b1;
      end else begin
        alu_ctrl_d = sel_ctrl;
        alu_a_d    = sel_a;
        alu_b_d    = sel_b;
        rsp_err_d  = 1'b0;
      end
`else
      alu_ctrl_d = sel_ctrl;
      alu_a_d    = sel_a;
      alu_b_d    = sel_b;
`endif
    end
  end

  // State and datapath registers; reset drops any in-flight op at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      alu_ctrl_q   <= 4'b0010;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign alu_ctrl   = alu_ctrl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single-cycle core's one ALU between two requesters, e.g. the execute stage and a secondary address/compare unit. Each requester presents an ALU control code and two operands over a valid/ready handshake. The block grants one requester round-robin and drives the shared ALU from registered operands. It returns the registered result, zero flag and requester ID over a valid/ready response channel.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N has an operation
- req0_ready / req1_ready  out  1  requester N's operation accepted this cycle
- req0_ctrl / req1_ctrl  in  4  ALU code: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_ctrl  out  4  to shared ALU
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_result  in  WIDTH  from shared ALU (combinational)
- alu_zero  in  1  from shared ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the op (0/1)
- rsp_result  out  WIDTH  registered ALU result
- rsp_zero  out  1  registered zero flag
- rsp_err  out  1  illegal control code (see Configuration)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Round-robin pointer `prio` names the preferred requester.
- Grant: if both valid, grant `prio`; if one valid, grant it. reqN_ready is combinational: (state==IDLE, or state==RESP && rsp_ready) && grant==N. It is never high for both requesters and never high while reset is asserted.
- On accept: latch ctrl/a/b into the alu_* registers and the ID into rsp_id; next state EXEC. After every accept, `prio` becomes the non-granted requester.
- EXEC: the alu_* registers are stable for the whole cycle. At the edge, capture alu_result/alu_zero into rsp_result/rsp_zero; next state RESP.
- RESP: rsp_valid=1. rsp_id/rsp_result/rsp_zero/rsp_err are held stable until rsp_ready.
  - On rsp_ready with no request pending: go to IDLE.
  - On rsp_ready with a request pending: accept it in the same cycle and go straight to EXEC (back-to-back).
- In IDLE and RESP the alu_* outputs hold their last issued values. They change only on accept.
- Requester-side rule: once a requester raises valid, it holds valid and its ctrl/a/b stable until ready. The block does not check this.

## Timing
- Reset values: state IDLE, prio=0, alu_ctrl=4'b0010, alu_a=0, alu_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0.
- Latency: accept at edge T, EXEC cycle T..T+1, rsp_valid high from T+2.
- Throughput: one op per 2 cycles when rsp_ready is held high and requests are continuous.
- Responses come out in accept order. At most one transaction is in flight.
- Reset asserted mid-transaction: the in-flight op is dropped immediately (asynchronously) and no response is issued. Operation resumes from IDLE on the first edge after deassertion.
- Simultaneous valid on both requesters in the first post-reset cycle: requester 0 wins.

## Configuration
- ALU_ARB_ILLEGAL_CHK_EN defined:
  - On accept, any req ctrl not in {0000, 0001, 0010, 0110, 0111} skips EXEC and goes directly to RESP.
  - The response carries rsp_result=0, rsp_zero=0, rsp_err=1, and the alu_* registers are not updated.
  - Latency for an illegal op is 1 cycle (rsp_valid from T+1).
- ALU_ARB_ILLEGAL_CHK_EN undefined: every code passes to alu_ctrl unchanged, and rsp_err is constant 0.

## Test plan
- Single op: reset, then req0 {0010, a=5, b=7} -> req0_ready for 1 cycle, alu_ctrl=0010/alu_a=5/alu_b=7 in EXEC, rsp_valid at T+2 with rsp_id=0, rsp_result=12, rsp_zero=0.
- Contention: both valid from the first cycle after reset, req0 SUB 9-9, req1 OR 4|1 -> req0 granted first (rsp_result=0, rsp_zero=1), then req1 (rsp_result=5, rsp_id=1); next contention grants req0 again only after req1 has been served.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_* stable, no reqN_ready, busy=1; on rsp_ready with req1 pending, req1_ready is high the same cycle and the next rsp_valid appears 2 cycles later.
- Streaming: req0 SLT ops (3<8, then 8<3) with rsp_ready tied high -> responses 1 then 0 spaced exactly 2 cycles apart.
- Reset mid-op: assert reset during EXEC -> rsp_valid stays 0 and all outputs go to their reset values immediately; the next request completes normally.
- With ALU_ARB_ILLEGAL_CHK_EN: req1 ctrl=1111 -> rsp_err=1, rsp_result=0, rsp_id=1 at T+1, alu_ctrl unchanged. Without the macro: alu_ctrl=1111 and rsp_err=0.
